// File: rtl/pc_control_fsm_pkg.sv
// pc_control_fsm_pkg
// Shared definitions for the PC control FSM:
//   - FSM state encoding (3-bit)
//   - opcode / extension field values used to classify instructions
//   - branch/jump condition codes
//   - PSR bit positions inside the 5-bit flags bus {N,Z,F,L,C}
//   - a helper that maps opcode/extension fields to an instruction class
package pc_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3
    } state_t;

    // Primary opcode (instr[15:12]) values
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_EXT   = 4'b0100;   // op whose ext field selects the operation

    // Extension (instr[7:4]) values under OP_EXT
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // Condition codes (instr[11:8])
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    // PSR bit indices in flags[4:0]
    localparam int unsigned PSR_N = 4;
    localparam int unsigned PSR_Z = 3;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_L = 1;
    localparam int unsigned PSR_C = 0;

    typedef enum logic [2:0] {
        IC_ALU   = 3'd0,
        IC_BCOND = 3'd1,
        IC_JCOND = 3'd2,
        IC_JAL   = 3'd3,
        IC_LOAD  = 3'd4,
        IC_STOR  = 3'd5,
        IC_UNDEF = 3'd6    // unused OP_EXT extension: advances PC, writes nothing
    } iclass_t;

    function automatic iclass_t classify(input logic [3:0] op, input logic [3:0] ext);
        iclass_t cls;
        if (op == OP_BCOND) begin
            cls = IC_BCOND;
        end else if (op == OP_EXT) begin
            case (ext)
                EXT_LOAD:  cls = IC_LOAD;
                EXT_STOR:  cls = IC_STOR;
                EXT_JAL:   cls = IC_JAL;
                EXT_JCOND: cls = IC_JCOND;
                default:   cls = IC_UNDEF;
            endcase
        end else begin
            cls = IC_ALU;
        end
        return cls;
    endfunction

endpackage

// File: rtl/pc_control_fsm_cond_eval.sv
// cond_eval
// Combinational branch/jump condition evaluator.
// Ports:
//   cond  [3:0] in  : condition code field
//   flags [4:0] in  : PSR {N,Z,F,L,C}
//   taken       out : 1 when the condition holds
module cond_eval
    import pc_control_fsm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    logic n_s, z_s, f_s, l_s, c_s;

    assign n_s = flags[PSR_N];
    assign z_s = flags[PSR_Z];
    assign f_s = flags[PSR_F];
    assign l_s = flags[PSR_L];
    assign c_s = flags[PSR_C];

    // Condition-code truth table
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken = z_s;
            CC_NE:   taken = ~z_s;
            CC_CS:   taken = c_s;
            CC_CC:   taken = ~c_s;
            CC_HI:   taken = l_s;
            CC_LS:   taken = ~l_s;
            CC_GT:   taken = n_s;
            CC_LE:   taken = ~n_s;
            CC_FS:   taken = f_s;
            CC_FC:   taken = ~f_s;
            CC_LO:   taken = ~l_s & ~z_s;
            CC_HS:   taken = l_s | z_s;
            CC_LT:   taken = ~n_s & ~z_s;
            CC_GE:   taken = n_s | z_s;
            CC_UC:   taken = 1'b1;
            CC_NV:   taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control_fsm.sv
// pc_control_fsm
// Multicycle control FSM: FETCH -> DECODE -> EXEC [-> MEM] -> FETCH.
// Latches the instruction in DECODE and issues exactly one PC-update strobe
// per instruction in its final state, together with register-file /
// data-memory write enables and the memory address select.
// Ports:
//   clk            in  : clock, rising edge
//   rst            in  : synchronous active-low reset
//   instr   [W-1:0] in : instruction memory read data (valid in DECODE)
//   flags   [4:0]  in  : PSR {N,Z,F,L,C}, evaluated in EXEC
//   increment, jal, displace, replace, unconditional out : PC strobes
//   immwire [W-1:0] out: sign-extended ir[7:0]
//   ir      [W-1:0] out: instruction register
//   rf_we, mem_we  out : write enables
//   addr_sel       out : 0 = PC, 1 = register A data
//   state   [2:0]  out : current FSM state
module pc_control_fsm
    import pc_control_fsm_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instr,
    input  logic [4:0]        flags,
    output logic              increment,
    output logic              jal,
    output logic              displace,
    output logic              replace,
    output logic              unconditional,
    output logic [ADDR_W-1:0] immwire,
    output logic [ADDR_W-1:0] ir,
    output logic              rf_we,
    output logic              mem_we,
    output logic              addr_sel,
    output logic [2:0]        state
);

    state_t              state_r;
    state_t              next_s;
    logic [ADDR_W-1:0]   ir_r;
    iclass_t             iclass_s;
    logic                taken_s;

    assign iclass_s = classify(ir_r[15:12], ir_r[7:4]);

    cond_eval u_cond_eval (
        .cond  (ir_r[11:8]),
        .flags (flags),
        .taken (taken_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Instruction register: loads in DECODE, holds elsewhere
    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_r <= '0;
        end else if (state_r == ST_DECODE) begin
            ir_r <= instr;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = ST_FETCH;
        case (state_r)
            ST_FETCH:  next_s = ST_DECODE;
            ST_DECODE: next_s = ST_EXEC;
            ST_EXEC: begin
                if ((iclass_s == IC_LOAD) || (iclass_s == IC_STOR)) begin
                    next_s = ST_MEM;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_MEM:    next_s = ST_FETCH;
            default:   next_s = ST_FETCH;
        endcase
    end

    // Output decode; reset forces every strobe and write low so an
    // instruction caught by reset in EXEC/MEM has no side effect.
    always_comb begin
        increment     = 1'b0;
        jal           = 1'b0;
        displace      = 1'b0;
        replace       = 1'b0;
        unconditional = 1'b0;
        rf_we         = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        if (!rst) begin
            addr_sel = 1'b0;
        end else begin
            case (state_r)
                ST_EXEC: begin
                    case (iclass_s)
                        IC_ALU: begin
                            rf_we     = 1'b1;
                            increment = 1'b1;
                        end
                        IC_BCOND: begin
                            if (taken_s) begin
                                displace = 1'b1;
                            end else begin
                                increment = 1'b1;
                            end
                        end
                        IC_JCOND: begin
                            if (!taken_s) begin
                                increment = 1'b1;
                            end else if (ir_r[11:8] == CC_UC) begin
                                unconditional = 1'b1;
                            end else begin
                                replace = 1'b1;
                            end
                        end
                        IC_JAL: begin
                            jal   = 1'b1;
                            rf_we = 1'b1;
                        end
                        IC_UNDEF: increment = 1'b1;
                        // LOAD/STOR finish in MEM
                        default:  increment = 1'b0;
                    endcase
                end
                ST_MEM: begin
                    addr_sel  = 1'b1;
                    increment = 1'b1;
                    if (iclass_s == IC_STOR) begin
                        mem_we = 1'b1;
                    end else begin
                        rf_we = 1'b1;
                    end
                end
                default: addr_sel = 1'b0;
            endcase
        end
    end

    assign state   = state_r;
    assign ir      = ir_r;
    assign immwire = {{(ADDR_W-8){ir_r[7]}}, ir_r[7:0]};

endmodule

// File: tb/tb_pc_control_fsm.sv
// tb_pc_control_fsm
// Self-checking bench: directed instructions followed by random ones,
// with occasional reset pulses, checked cycle-by-cycle against an
// instruction-level reference model.
module tb_pc_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [4:0]  flags = 5'b00000;

    logic        increment, jal, displace, replace, unconditional;
    logic [15:0] immwire, ir;
    logic        rf_we, mem_we, addr_sel;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    // strobe vector bit positions: {inc,jal,disp,repl,unc,rf_we,mem_we,addr_sel}
    localparam logic [7:0] E_INC  = 8'h80;
    localparam logic [7:0] E_JAL  = 8'h40;
    localparam logic [7:0] E_DISP = 8'h20;
    localparam logic [7:0] E_REPL = 8'h10;
    localparam logic [7:0] E_UNC  = 8'h08;
    localparam logic [7:0] E_RF   = 8'h04;
    localparam logic [7:0] E_MEM  = 8'h02;
    localparam logic [7:0] E_ASEL = 8'h01;

    logic [7:0] outs_s;
    assign outs_s = {increment, jal, displace, replace, unconditional, rf_we, mem_we, addr_sel};

    always #5 clk = ~clk;

    pc_control_fsm #(.ADDR_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .flags         (flags),
        .increment     (increment),
        .jal           (jal),
        .displace      (displace),
        .replace       (replace),
        .unconditional (unconditional),
        .immwire       (immwire),
        .ir            (ir),
        .rf_we         (rf_we),
        .mem_we        (mem_we),
        .addr_sel      (addr_sel),
        .state         (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs: even code = base, odd = inverse.
    function automatic bit ref_taken(input logic [3:0] c, input logic [4:0] f);
        bit n, z, fl, l, cy, base;
        n = f[4]; z = f[3]; fl = f[2]; l = f[1]; cy = f[0];
        case (c >> 1)
            0: base = z;
            1: base = cy;
            2: base = l;
            3: base = n;
            4: base = fl;
            5: base = !l && !z;
            6: base = !n && !z;
            default: return (c == 4'hE);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic bit is_mem(input logic [15:0] i);
        return (i[15:12] == 4'h4) && ((i[7:4] == 4'h0) || (i[7:4] == 4'h4));
    endfunction

    function automatic logic [7:0] ref_exec(input logic [15:0] i, input logic [4:0] f);
        bit t;
        t = ref_taken(i[11:8], f);
        if (i[15:12] == 4'hC) return t ? E_DISP : E_INC;
        if (i[15:12] != 4'h4) return E_INC | E_RF;
        case (i[7:4])
            4'h0, 4'h4: return 8'h00;
            4'h8:       return E_JAL | E_RF;
            4'hC:       return !t ? E_INC : ((i[11:8] == 4'hE) ? E_UNC : E_REPL);
            default:    return E_INC;
        endcase
    endfunction

    function automatic logic [7:0] ref_mem(input logic [15:0] i);
        return (i[7:4] == 4'h4) ? (E_INC | E_MEM | E_ASEL) : (E_INC | E_RF | E_ASEL);
    endfunction

    // Runs one instruction; abort_at = cycle index (0..3) to pulse reset, or -1.
    task automatic run_instr(input logic [15:0] i, input logic [4:0] f, input int abort_at);
        int ncyc;
        logic [7:0] e;
        logic [15:0] sx;
        ncyc = is_mem(i) ? 4 : 3;
        for (int c = 0; c < ncyc; c++) begin
            instr = (c == 1) ? i : 16'($urandom);
            flags = (c == 2) ? f : 5'($urandom);
            rst   = (c == abort_at) ? 1'b0 : 1'b1;
            case (c)
                2:       e = ref_exec(i, f);
                3:       e = ref_mem(i);
                default: e = 8'h00;
            endcase
            @(negedge clk);
            check("state", 32'(state), 32'(c));
            if (c == abort_at) begin
                check("abort_strobes", 32'(outs_s & 8'hFE), 32'h0);
                @(posedge clk); #1;
                rst = 1'b1;
                check("abort_state", 32'(state), 32'h0);
                check("abort_ir", 32'(ir), 32'h0);
                return;
            end
            check("strobes", 32'(outs_s), 32'(e));
            if (c == 2) begin
                sx = 16'($signed(i[7:0]));
                check("ir", 32'(ir), 32'(i));
                check("immwire", 32'(immwire), 32'(sx));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [15:0] ri;
        logic [4:0]  rf;
        int          ab;

        // reset state
        rst = 1'b0;
        @(negedge clk);
        check("rst_strobes", 32'(outs_s & 8'hFE), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", 32'(state), 32'h0);
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_strobes2", 32'(outs_s & 8'hFE), 32'h0);
        @(posedge clk); #1;

        // directed vectors
        run_instr(16'h0512, 5'b00000, -1);   // ADD
        run_instr(16'hC0FC, 5'b01000, -1);   // BEQ taken
        run_instr(16'hC0FC, 5'b00000, -1);   // BEQ not taken
        run_instr(16'h4EC3, 5'b00000, -1);   // JUC
        run_instr(16'h41C3, 5'b00000, -1);   // JNE taken
        run_instr(16'h41C3, 5'b01000, -1);   // JNE not taken
        run_instr(16'h4283, 5'b10101, -1);   // JAL
        run_instr(16'h4241, 5'b00000, -1);   // STOR
        run_instr(16'h4301, 5'b00000, -1);   // LOAD
        run_instr(16'h4FC0, 5'b11111, -1);   // Jcond never
        run_instr(16'h4021, 5'b00000, -1);   // undefined ext
        run_instr(16'h4241, 5'b00000, 3);    // STOR aborted in MEM
        run_instr(16'h0512, 5'b00000, -1);

        // random instructions, occasional aborts
        for (int k = 0; k < 400; k++) begin
            ri = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       ri[15:12] = 4'h4;
                1:       ri[15:12] = 4'hC;
                default: ri[15:12] = ri[15:12];
            endcase
            rf = 5'($urandom);
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(ri, rf, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_control_fsm.md
PC_CONTROL_FSM -- requirements
Module: pc_control_fsm

Interface
REQ-001 Parameter: ADDR_W, default 16, width of the instruction word, PC, immediate and sign-extended displacement.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low: sampled only on the clk rising edge, asserted when 0.
REQ-004 instr  input  16  instruction memory read data, valid the cycle after FETCH.
REQ-005 flags  input  5  PSR {N,Z,F,L,C}, bit 4 = N.
REQ-006 increment, jal, displace, replace, unconditional  output  1 each  one-cycle PC-update strobes to the PC counter.
REQ-007 immwire  output  16  sign-extended instr[7:0] branch displacement.
REQ-008 ir  output  16  latched instruction register.
REQ-009 rf_we  output  1  register-file write enable.
REQ-010 mem_we  output  1  data-memory write enable.
REQ-011 addr_sel  output  1  memory address mux: 0 = PC, 1 = register A data.
REQ-012 state  output  3  current FSM state, for debug.

Function
REQ-013 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, with 3-bit encoding.
REQ-014 Transitions: FETCH->DECODE->EXEC unconditionally.
REQ-015 EXEC->MEM for LOAD (op 0100, ext 0000) and STOR (op 0100, ext 0100); EXEC->FETCH for all other instructions.
REQ-016 MEM->FETCH unconditionally.
REQ-017 FETCH drives addr_sel=0 and all strobes low.
REQ-018 DECODE loads ir<=instr.
REQ-019 ir holds its value in every other state.
REQ-020 Exactly one PC strobe fires per instruction, in its final state; the strobes are mutually exclusive.
REQ-021 ALU/immediate ops (any op other than 0100 or 1100) in EXEC: rf_we=1, increment=1.
REQ-022 Bcond (op 1100, cond=ir[11:8]) in EXEC: displace=1 if taken, else increment=1; rf_we=0.
REQ-023 Jcond (op 0100, ext 1100, cond=ir[11:8]) in EXEC, not taken: increment=1.
REQ-024 Jcond in EXEC, taken with cond=UC: unconditional=1.
REQ-025 Jcond in EXEC, taken with any other cond: replace=1.
REQ-026 JAL (op 0100, ext 1000) in EXEC: jal=1, rf_we=1 (link = oldpc).
REQ-027 LOAD in MEM: addr_sel=1, rf_we=1, increment=1.
REQ-028 STOR in MEM: addr_sel=1, mem_we=1, increment=1.
REQ-029 Condition codes (1 = taken): EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N; FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 always; 1111 never.
REQ-030 Condition evaluation uses flags sampled in EXEC.
REQ-031 immwire = {{8{ir[7]}}, ir[7:0]}, combinational from ir.
REQ-032 Throughput: 3 cycles per non-memory instruction, 4 per LOAD/STOR.
REQ-033 Undefined op-0100 extensions are treated as ALU no-write: increment only, rf_we=0.

Reset
REQ-034 When rst=0 at a rising edge: state<=FETCH, ir<=0.
REQ-035 All strobes, rf_we and mem_we are 0 during the reset cycle, with priority over any state.
REQ-036 Reset asserted in EXEC or MEM aborts the instruction: no strobe or write occurs in that cycle.
REQ-037 First FETCH occurs in the first cycle with rst=1.

Structure
REQ-038 A shared package holds: state encodings, opcode/ext constants (BCOND, JCOND, JAL, LOAD, STOR), condition-code constants, and PSR bit indices.
REQ-039 One sub-module, cond_eval (cond[3:0], flags[4:0] -> taken), is combinational and is reused by the ALU-flag checker.

Verification
REQ-040 Reset then ADD (0x0512) -> states 0,1,2,0; rf_we and increment high only in EXEC.
REQ-041 BEQ disp 0xFC (0xC0FC), Z=1 -> displace=1, immwire=0xFFFC; same with Z=0 -> increment=1, displace=0.
REQ-042 JUC (0x4EC3) -> unconditional=1; JNE (0x41C3), Z=0 -> replace=1; JNE with Z=1 -> increment=1.
REQ-043 JAL (0x4283) -> jal=1 and rf_we=1 in EXEC; no other strobe.
REQ-044 STOR (0x4241) -> MEM state entered, mem_we=1, addr_sel=1, increment=1; LOAD -> rf_we=1 in MEM.
REQ-045 rst=0 pulse during MEM of a STOR -> mem_we=0 that cycle, state=FETCH next, ir=0.
